// File: rtl/period_step_ctrl.sv
// Blink-period controller: inc/dec keys with hold auto-repeat and
// saturating steps, plus a blink phase generated from the 1 kHz tick.
//   clk, rst         : system clock, synchronous active-high reset
//   tick_1ms         : one-clk strobe at 1 kHz
//   key_dec, key_inc : debounced active-low key levels
//   period           : current half-cycle period in ms
//   period_upd       : one-clk pulse whenever period changes
//   at_min, at_max   : period sits at a limit
//   blink            : blink phase, toggles every `period` ticks
module period_step_ctrl #(
  parameter int PERIOD_DEF = 1000,
  parameter int PERIOD_MIN = 50,
  parameter int PERIOD_MAX = 1000,
  parameter int STEP       = 50,
  parameter int HOLD_DELAY = 500,
  parameter int REPEAT_MS  = 100,
  parameter int PW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1ms,
  input  logic          key_dec,
  input  logic          key_inc,
  output logic [PW-1:0] period,
  output logic          period_upd,
  output logic          at_min,
  output logic          at_max,
  output logic          blink
);

  localparam logic [PW-1:0] P_DEF   = PW'(PERIOD_DEF);
  localparam logic [PW-1:0] P_MIN   = PW'(PERIOD_MIN);
  localparam logic [PW-1:0] P_MAX   = PW'(PERIOD_MAX);
  localparam logic [PW-1:0] P_STEP  = PW'(STEP);
  localparam logic [PW-1:0] DEC_LIM = PW'(PERIOD_MIN + STEP);
  localparam logic [PW-1:0] INC_LIM = PW'(PERIOD_MAX - STEP);
  localparam logic [PW-1:0] H_LAST  = PW'(HOLD_DELAY - 1);
  localparam logic [PW-1:0] R_LAST  = PW'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    LOCK
  } state_e;

  state_e        state_q, state_d;
  logic          act_dec_q, act_dec_d;
  logic [PW-1:0] hcnt_q, hcnt_d;
  logic [PW-1:0] period_q, period_d;
  logic          upd_q;
  logic [PW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic          key_dec_q, key_inc_q;

  logic dec_press, inc_press;
  logic act_low, oth_low;
  logic do_step, step_dec;

  assign dec_press = !key_dec && key_dec_q;
  assign inc_press = !key_inc && key_inc_q;
  assign act_low   = act_dec_q ? !key_dec : !key_inc;
  assign oth_low   = act_dec_q ? !key_inc : !key_dec;

  always_comb begin
    state_d   = state_q;
    act_dec_d = act_dec_q;
    hcnt_d    = hcnt_q;
    do_step   = 1'b0;
    step_dec  = act_dec_q;
    unique case (state_q)
      IDLE: begin
        if (!key_dec && !key_inc) begin
          state_d = LOCK;
        end else if (dec_press || inc_press) begin
          do_step   = 1'b1;
          step_dec  = dec_press;
          act_dec_d = dec_press;
          hcnt_d    = '0;
          state_d   = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (oth_low) begin
          state_d = LOCK;
        end else if (!act_low) begin
          state_d = IDLE;
        end else if (tick_1ms) begin
          if (hcnt_q == ((state_q == HOLD) ? H_LAST : R_LAST)) begin
            do_step = 1'b1;
            hcnt_d  = '0;
            state_d = REPEAT;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      LOCK: begin
        if (key_dec && key_inc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Limits are checked before the add/subtract so the value never wraps.
  always_comb begin
    period_d = period_q;
    if (do_step) begin
      if (step_dec) begin
        period_d = (period_q >= DEC_LIM) ? period_q - P_STEP : P_MIN;
      end else begin
        period_d = (period_q <= INC_LIM) ? period_q + P_STEP : P_MAX;
      end
    end
  end

  // >= lets a period drop below the running count toggle on the next tick.
  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (tick_1ms) begin
      if (bcnt_q >= period_q - 1'b1) begin
        bcnt_d  = '0;
        blink_d = !blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      act_dec_q <= 1'b0;
      hcnt_q    <= '0;
      period_q  <= P_DEF;
      upd_q     <= 1'b0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      key_dec_q <= 1'b1;
      key_inc_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      act_dec_q <= act_dec_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      upd_q     <= (period_d != period_q);
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      key_dec_q <= key_dec;
      key_inc_q <= key_inc;
    end
  end

  assign period     = period_q;
  assign period_upd = upd_q;
  assign at_min     = (period_q == P_MIN);
  assign at_max     = (period_q == P_MAX);
  assign blink      = blink_q;

endmodule

// File: tb/tb_period_step_ctrl.sv
// Self-checking bench for period_step_ctrl against a behavioural model
// that tracks held-time in ticks and derives steps arithmetically.
module tb_period_step_ctrl;

  localparam int PW   = 10;
  localparam int DEF  = 1000;
  localparam int MIN  = 50;
  localparam int MAX  = 1000;
  localparam int STP  = 50;
  localparam int HD   = 500;
  localparam int RMS  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_1ms = 1'b0;
  logic key_dec = 1'b1;
  logic key_inc = 1'b1;
  logic [PW-1:0] period;
  logic period_upd, at_min, at_max, blink;

  int checks = 0;
  int errors = 0;

  // model state: mode 0 released, 1 key held, 2 locked out
  int m_period, m_ph, m_mode, m_ht;
  bit m_blink, m_upd, m_dec, m_pkd, m_pki;

  period_step_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1ms  (tick_1ms),
    .key_dec   (key_dec),
    .key_inc   (key_inc),
    .period    (period),
    .period_upd(period_upd),
    .at_min    (at_min),
    .at_max    (at_max),
    .blink     (blink)
  );

  always #10 clk = ~clk;

  function automatic int step_val(int p, bit dn);
    int r;
    if (dn) begin
      r = p - STP;
      if (r < MIN) r = MIN;
    end else begin
      r = p + STP;
      if (r > MAX) r = MAX;
    end
    return r;
  endfunction

  task automatic model(bit r, bit kd, bit ki, bit tk);
    int  np;
    bit  al, ol;
    if (r) begin
      m_period = DEF; m_ph = 0; m_blink = 0; m_upd = 0;
      m_mode = 0; m_ht = 0; m_pkd = 1; m_pki = 1;
      return;
    end
    np = m_period;
    if (m_mode == 0) begin
      if (!kd && !ki) m_mode = 2;
      else if (!kd && m_pkd) begin
        np = step_val(np, 1); m_mode = 1; m_dec = 1; m_ht = 0;
      end else if (!ki && m_pki) begin
        np = step_val(np, 0); m_mode = 1; m_dec = 0; m_ht = 0;
      end
    end else if (m_mode == 1) begin
      al = m_dec ? !kd : !ki;
      ol = m_dec ? !ki : !kd;
      if (ol) m_mode = 2;
      else if (!al) m_mode = 0;
      else if (tk) begin
        m_ht++;
        if (m_ht == HD || (m_ht > HD && (m_ht - HD) % RMS == 0))
          np = step_val(np, m_dec);
      end
    end else begin
      if (kd && ki) m_mode = 0;
    end
    if (tk) begin
      if (m_ph + 1 >= m_period) begin
        m_ph = 0; m_blink = !m_blink;
      end else m_ph++;
    end
    m_upd = (np != m_period);
    m_period = np;
    m_pkd = kd; m_pki = ki;
  endtask

  function automatic logic [PW+3:0] exp_vec();
    return {PW'(m_period), m_upd, m_blink, m_period == MIN, m_period == MAX};
  endfunction

  task automatic drive(bit r, bit kd, bit ki, bit tk);
    rst = r; key_dec = kd; key_inc = ki; tick_1ms = tk;
    @(posedge clk);
    model(r, kd, ki, tk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    drive(1, 1, 1, 0);
    checks++;
    if (period !== 10'd1000) begin
      errors++; $display("FAIL reset_period got %0d exp 1000", period);
    end
    checks++;
    if (period_upd !== 1'b0 || blink !== 1'b0) begin
      errors++; $display("FAIL reset_upd_blink got %b%b exp 00", period_upd, blink);
    end
    checks++;
    if (at_max !== 1'b1 || at_min !== 1'b0) begin
      errors++; $display("FAIL reset_limits got %b%b exp 10", at_max, at_min);
    end
  endtask

  task automatic test_idle_blink;
    int tg = 0, up = 0, tks = 0;
    bit pb = 0;
    drive(1, 1, 1, 0);
    for (int i = 0; i < 5000; i++) begin
      drive(0, 1, 1, (i % 2) == 0);
      if ((i % 2) == 0) tks++;
      checks++;
      if ({period, period_upd, blink, at_min, at_max} !== exp_vec()) begin
        errors++;
        $display("FAIL idle cyc %0d got %h exp %h", i,
                 {period, period_upd, blink, at_min, at_max}, exp_vec());
      end
      if (blink != pb) begin
        tg++;
        checks++;
        if (tks != 1000 * tg) begin
          errors++; $display("FAIL idle_toggle_tick got %0d exp %0d", tks, 1000 * tg);
        end
      end
      pb = blink;
      if (period_upd) up++;
    end
    checks++;
    if (tg != 2 || up != 0) begin
      errors++; $display("FAIL idle_counts toggles %0d upd %0d exp 2 0", tg, up);
    end
  endtask

  task automatic test_single_press;
    int up = 0;
    drive(1, 1, 1, 0);
    drive(0, 0, 1, 0);
    checks++;
    if (period !== 10'd950 || period_upd !== 1'b1) begin
      errors++; $display("FAIL press_latency got %0d/%b exp 950/1", period, period_upd);
    end
    for (int i = 0; i < 24; i++) begin
      drive(0, i >= 20, 1, (i % 2) == 0);
      if (period_upd) up++;
      checks++;
      if ({period, period_upd, blink, at_min, at_max} !== exp_vec()) begin
        errors++;
        $display("FAIL press cyc %0d got %h exp %h", i,
                 {period, period_upd, blink, at_min, at_max}, exp_vec());
      end
    end
    checks++;
    if (up != 0 || period !== 10'd950) begin
      errors++; $display("FAIL press_single extra %0d period %0d exp 0 950", up, period);
    end
  endtask

  task automatic test_hold_repeat;
    int up = 0;
    drive(1, 1, 1, 0);
    for (int i = 0; i <= 2000; i++) begin
      drive(0, 0, 1, (i % 2) == 0);
      if (period_upd) up++;
      checks++;
      if ({period, period_upd, blink, at_min, at_max} !== exp_vec()) begin
        errors++;
        $display("FAIL hold cyc %0d got %h exp %h", i,
                 {period, period_upd, blink, at_min, at_max}, exp_vec());
      end
    end
    checks++;
    if (period !== 10'd650 || up != 7) begin
      errors++; $display("FAIL hold_result got %0d/%0d exp 650/7", period, up);
    end
    drive(0, 1, 1, 0);
  endtask

  task automatic test_saturate;
    int up = 0;
    drive(1, 1, 1, 0);
    for (int i = 0; i < 20000; i++) begin
      drive(0, 0, 1, (i % 2) == 0);
      if (period_upd) up++;
      checks++;
      if ({period, period_upd, blink, at_min, at_max} !== exp_vec()) begin
        errors++;
        $display("FAIL sat cyc %0d got %h exp %h", i,
                 {period, period_upd, blink, at_min, at_max}, exp_vec());
      end
    end
    checks++;
    if (period !== 10'd50 || at_min !== 1'b1 || up != 19) begin
      errors++; $display("FAIL sat_result got %0d/%b/%0d exp 50/1/19", period, at_min, up);
    end
    drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    checks++;
    if (period !== 10'd50 || period_upd !== 1'b0) begin
      errors++; $display("FAIL sat_min_press got %0d/%b exp 50/0", period, period_upd);
    end
    drive(1, 1, 1, 0);
    drive(0, 1, 0, 0);
    checks++;
    if (period !== 10'd1000 || period_upd !== 1'b0) begin
      errors++; $display("FAIL sat_max_press got %0d/%b exp 1000/0", period, period_upd);
    end
    drive(0, 1, 1, 0);
  endtask

  task automatic test_lock;
    int up = 0;
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 1200; i++) begin
      drive(0, 0, 1, (i % 2) == 0);
      if (period_upd) up++;
      checks++;
      if ({period, period_upd, blink, at_min, at_max} !== exp_vec()) begin
        errors++;
        $display("FAIL lock cyc %0d got %h exp %h", i,
                 {period, period_upd, blink, at_min, at_max}, exp_vec());
      end
    end
    checks++;
    if (up != 0 || period !== 10'd1000) begin
      errors++; $display("FAIL lock_nostep got %0d/%0d exp 1000/0", period, up);
    end
    drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    checks++;
    if (period !== 10'd950 || period_upd !== 1'b1) begin
      errors++; $display("FAIL lock_resume got %0d/%b exp 950/1", period, period_upd);
    end
    drive(0, 1, 1, 0);
  endtask

  task automatic test_blink_counter;
    int tks = 0, hit = -1;
    drive(1, 1, 1, 0);
    for (int i = 0; i < 2600; i++) begin
      bit tk;
      tk = (i % 2) == 0 && i != 1200 && i != 1201;
      drive(0, i != 1200, 1, tk);
      if (tk) tks++;
      if (blink && hit < 0) hit = tks;
      checks++;
      if ({period, period_upd, blink, at_min, at_max} !== exp_vec()) begin
        errors++;
        $display("FAIL bcnt cyc %0d got %h exp %h", i,
                 {period, period_upd, blink, at_min, at_max}, exp_vec());
      end
    end
    checks++;
    if (hit != 950) begin
      errors++; $display("FAIL bcnt_toggle_tick got %0d exp 950", hit);
    end
    drive(1, 1, 1, 0);
    for (int i = 0; i < 1200; i++) drive(0, 1, 1, (i % 2) == 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0);
      drive(0, 1, 1, 0);
    end
    checks++;
    if (period !== 10'd500 || blink !== 1'b0) begin
      errors++; $display("FAIL bcnt_shrink got %0d/%b exp 500/0", period, blink);
    end
    drive(0, 1, 1, 1);
    checks++;
    if (blink !== 1'b1) begin
      errors++; $display("FAIL bcnt_next_tick got %b exp 1", blink);
    end
    for (int i = 0; i < 1300; i++) drive(0, 0, 1, (i % 2) == 0);
    drive(1, 0, 1, 0);
    checks++;
    if (period !== 10'd1000 || blink !== 1'b0 || period_upd !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_repeat got %0d/%b/%b exp 1000/0/0", period, blink, period_upd);
    end
    drive(0, 1, 1, 0);
  endtask

  task automatic test_random;
    bit kd = 1, ki = 1, r;
    drive(1, 1, 1, 0);
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 149) == 0) kd = $urandom_range(0, 1);
      if ($urandom_range(0, 149) == 0) ki = $urandom_range(0, 1);
      r = ($urandom_range(0, 2999) == 0);
      if (r) begin kd = 1; ki = 1; end
      drive(r, kd, ki, $urandom_range(0, 1));
      checks++;
      if ({period, period_upd, blink, at_min, at_max} !== exp_vec()) begin
        errors++;
        $display("FAIL rand cyc %0d got %h exp %h", i,
                 {period, period_upd, blink, at_min, at_max}, exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_blink();
    test_single_press();
    test_hold_repeat();
    test_saturate();
    test_lock();
    test_blink_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_step_ctrl.md
Name: period_step_ctrl

Overview:
Key-driven controller that owns the blink-period setting for the LED/frequency-display datapath. It turns debounced, active-low inc/dec key levels into saturating period steps, with press-and-hold auto-repeat. It also generates the blink phase from a 1 kHz tick strobe. It replaces the asynchronous key-edge period logic. All activity is on one clock; the 1 kHz timebase arrives as an enable strobe, not a derived clock.

Parameters:
PERIOD_DEF, 1000, reset period in ms (half-cycle of blink).
PERIOD_MIN, 50, lowest legal period.
PERIOD_MAX, 1000, highest legal period.
STEP, 50, period change per step.
HOLD_DELAY, 500, ms a key must stay held before auto-repeat starts.
REPEAT_MS, 100, ms between auto-repeat steps.
PW, 10, width of period and counters; must hold PERIOD_MAX.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high; the only reset in the block
tick_1ms  in  1  one-clk-wide strobe at 1 kHz
key_dec  in  1  debounced key level, active-low, requests shorter period (faster blink)
key_inc  in  1  debounced key level, active-low, requests longer period
period  out  PW  current period in ms; feeds display and frequency computation
period_upd  out  1  one-clk pulse on every clk where period changes
at_min  out  1  period == PERIOD_MIN
at_max  out  1  period == PERIOD_MAX
blink  out  1  blink phase; toggles every `period` ticks

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk, and rst has priority over all other logic.
- Reset values:
  - period = PERIOD_DEF; period_upd = 0; blink = 0.
  - at_min and at_max follow PERIOD_DEF (defaults give at_max = 1).
  - FSM = IDLE; hold counter = 0; blink counter = 0.
  - Key history registers = 1 (released).
- Keys are registered once (key_dec_q, key_inc_q). A press is key_x == 0 while key_x_q == 1.
- Step operation:
  - DEC: period <= max(period - STEP, PERIOD_MIN).
  - INC: period <= min(period + STEP, PERIOD_MAX).
  - Compare before subtracting, so there is no unsigned wrap.
  - A step attempted at a limit leaves period unchanged and gives no period_upd pulse.
- Latency: a single press changes period on the same posedge at which the low level is first sampled. period_upd is high for exactly that clk.
- FSM states:
  - IDLE:
    - one key pressed (new edge): apply one step, clear hold counter, go to HOLD;
    - both keys low: go to LOCK, no step.
  - HOLD:
    - count tick_1ms;
    - at HOLD_DELAY ticks: apply a step, clear counter, go to REPEAT;
    - active key released: go to IDLE.
  - REPEAT:
    - count tick_1ms;
    - every REPEAT_MS ticks: apply a step;
    - active key released: go to IDLE.
  - LOCK: no steps; go to IDLE only when both keys are high.
  - In HOLD or REPEAT, if the other key also goes low, go to LOCK on that clk with no step.
- The FSM records which key is active (dec/inc). Release of the non-active key is ignored.
- Blink counter (PW bits), advanced only on tick_1ms:
  - if cnt >= period - 1: cnt <= 0 and blink toggles;
  - otherwise cnt increments.
- Using >= means a period decrease below the current count toggles blink at the next tick. The count never runs past the period.
- A period change does not clear the blink counter.
- at_min and at_max are combinational from period.
- Reset mid-hold returns to IDLE and restores PERIOD_DEF. A key still held through reset does not cause a step, because its history register was reset to 1 and the key has no new edge.
- When tick_1ms and a key edge coincide, both take effect in the same clk.

Test Plan:
- Reset, then 2500 ticks with no keys -> period = 1000, at_max = 1, blink toggles at ticks 1000 and 2000, period_upd never pulses.
- key_dec low for 1 clk-sampled press, released at 10 ticks -> period = 950 one clk after the low level, single period_upd pulse, FSM returns to IDLE.
- key_dec held 1000 ticks from period = 1000:
  - steps at ticks 0, 500, 600, 700, 800, 900, 1000;
  - period = 650 (1000 - 7×50).
- key_dec held 10000 ticks -> period saturates at 50, at_min = 1, no pulses after saturation. key_inc at 1000 -> no change, no pulse.
- Both keys low in the same clk, then key_inc released while key_dec stays low -> no step, FSM stays in LOCK; steps resume only after both keys are released and key_dec is pressed again.
- Period 1000, blink counter at 600, then a dec press -> period 950, no toggle until tick 950. Separately: counter at 600, period forced to 500 by repeated presses -> toggle on the next tick. Assert rst mid-REPEAT -> period = 1000 next clk, blink = 0.
